// File: rtl/muldiv_seq_pkg.sv
// Shared CPU definitions for the multiply/divide resource: datapath width,
// op encodings and the sequencer state type.
package muldiv_seq_pkg;

   localparam int   MD_WIDTH = 32;

   localparam logic MD_MULT  = 1'b0;
   localparam logic MD_DIV   = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } md_state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the control FSM (master) and the
// multiply/divide sequencer (slave), plus the sequencer state for observation.
interface muldiv_seq_if
   import muldiv_seq_pkg::*;
   #(parameter int WIDTH = MD_WIDTH) ();

   // start is taken only while busy=0; done pulses one cycle and hi/lo are
   // valid from that cycle until the next completing operation.
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   md_state_e        dbg_state;

   modport master (
      output start, op, a_in, b_in,
      input  busy, done, div_zero, hi, lo, dbg_state
   );

   modport slave (
      input  start, op, a_in, b_in,
      output busy, done, div_zero, hi, lo, dbg_state
   );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: a radix-2 Booth step (MULT) or one restoring
// divide step on magnitudes (DIV).
module muldiv_step
   import muldiv_seq_pkg::*;
   #(parameter int WIDTH = MD_WIDTH) (
   input  logic             i_mode,
   input  logic [WIDTH:0]   i_acc,
   input  logic [WIDTH-1:0] i_mq,
   input  logic             i_q1,
   input  logic [WIDTH-1:0] i_m,
   output logic [WIDTH:0]   o_acc,
   output logic [WIDTH-1:0] o_mq,
   output logic             o_q1
);

   logic [WIDTH:0] w_m_ext;
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_acc_sh;
   logic [WIDTH:0] w_trial;

   // The extra accumulator bit keeps acc - (-2^(W-1)) from overflowing.
   always_comb begin
      w_m_ext  = (i_mode == MD_MULT) ? {i_m[WIDTH-1], i_m} : {1'b0, i_m};
      w_sum    = i_acc;
      w_acc_sh = {i_acc[WIDTH-1:0], i_mq[WIDTH-1]};
      w_trial  = w_acc_sh - w_m_ext;
      o_acc    = i_acc;
      o_mq     = i_mq;
      o_q1     = i_q1;
      if (i_mode == MD_MULT) begin
         case ({i_mq[0], i_q1})
            2'b01:   w_sum = i_acc + w_m_ext;
            2'b10:   w_sum = i_acc - w_m_ext;
            default: w_sum = i_acc;
         endcase
         o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
         o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
         o_q1  = i_mq[0];
      end else begin
         if (!w_trial[WIDTH]) begin
            o_acc = w_trial;
            o_mq  = {i_mq[WIDTH-2:0], 1'b1};
         end else begin
            o_acc = w_acc_sh;
            o_mq  = {i_mq[WIDTH-2:0], 1'b0};
         end
         o_q1 = 1'b0;
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Multicycle signed MULT/DIV sequencer owning the Hi/Lo result registers.
// One iteration per clock; done pulses once per accepted request.
module muldiv_seq
   import muldiv_seq_pkg::*;
   #(parameter int WIDTH = MD_WIDTH) (
   input  logic         i_clk,
   input  logic         i_reset,
   muldiv_seq_if.slave  s_md
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH - 1);

   md_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_mq;
   logic             r_q1;
   logic [WIDTH-1:0] r_m;
   logic             r_quo_neg;
   logic             r_rem_neg;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero;

   logic             w_mode;
   logic [WIDTH:0]   w_acc;
   logic [WIDTH-1:0] w_mq;
   logic             w_q1;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;

   // Magnitudes are unsigned, so |-2^(W-1)| = 2^(W-1) is exact.
   assign w_a_mag = s_md.a_in[WIDTH-1] ? -s_md.a_in : s_md.a_in;
   assign w_b_mag = s_md.b_in[WIDTH-1] ? -s_md.b_in : s_md.b_in;
   assign w_mode  = (r_state == S_DIV) ? MD_DIV : MD_MULT;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_mode (w_mode),
      .i_acc  (r_acc),
      .i_mq   (r_mq),
      .i_q1   (r_q1),
      .i_m    (r_m),
      .o_acc  (w_acc),
      .o_mq   (w_mq),
      .o_q1   (w_q1)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_mq       <= '0;
         r_q1       <= 1'b0;
         r_m        <= '0;
         r_quo_neg  <= 1'b0;
         r_rem_neg  <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done     <= 1'b0;
               r_div_zero <= 1'b0;
               if (s_md.start) begin
                  r_busy <= 1'b1;
                  r_acc  <= '0;
                  r_q1   <= 1'b0;
                  r_cnt  <= CNT_LOAD;
                  if (s_md.op == MD_MULT) begin
                     r_mq    <= s_md.b_in;
                     r_m     <= s_md.a_in;
                     r_state <= S_MUL;
                  end else if (s_md.b_in == '0) begin
                     r_done     <= 1'b1;
                     r_div_zero <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_mq      <= w_a_mag;
                     r_m       <= w_b_mag;
                     r_quo_neg <= s_md.a_in[WIDTH-1] ^ s_md.b_in[WIDTH-1];
                     r_rem_neg <= s_md.a_in[WIDTH-1];
                     r_state   <= S_DIV;
                  end
               end
            end
            S_MUL: begin
               r_acc <= w_acc;
               r_mq  <= w_mq;
               r_q1  <= w_q1;
               if (r_cnt == '0) begin
                  r_hi    <= w_acc[WIDTH-1:0];
                  r_lo    <= w_mq;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DIV: begin
               r_acc <= w_acc;
               r_mq  <= w_mq;
               r_q1  <= w_q1;
               if (r_cnt == '0) begin
                  r_state <= S_FIX;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_FIX: begin
               r_lo    <= r_quo_neg ? -r_mq : r_mq;
               r_hi    <= r_rem_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_done     <= 1'b0;
               r_div_zero <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_md.busy      = r_busy;
   assign s_md.done      = r_done;
   assign s_md.div_zero  = r_div_zero;
   assign s_md.hi        = r_hi;
   assign s_md.lo        = r_lo;
   assign s_md.dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: driver tasks push expected results into a queue,
// a monitor pops and compares on every done pulse.
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   localparam int W     = MD_WIDTH;
   localparam int EXP_W = 1 + 8 + 2 * W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   muldiv_seq_if #(.WIDTH(W)) md ();

   muldiv_seq #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .s_md    (md)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int               issue_q[$];
   int               n_checks = 0;
   int               n_errors = 0;
   logic [W-1:0]     model_hi = '0;
   logic [W-1:0]     model_lo = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain signed 64-bit arithmetic; / and % truncate toward zero.
   function automatic logic [EXP_W-1:0] ref_model(input logic op, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
      longint       la, lb, p, q, r;
      logic [W-1:0] hi, lo;
      logic         dz;
      logic [7:0]   lat;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      if (op == MD_MULT) begin
         p   = la * lb;
         hi  = p[2*W-1:W];
         lo  = p[W-1:0];
         dz  = 1'b0;
         lat = 8'(W + 1);
      end else if (b == '0) begin
         hi  = model_hi;
         lo  = model_lo;
         dz  = 1'b1;
         lat = 8'd1;
      end else begin
         q   = la / lb;
         r   = la % lb;
         hi  = r[W-1:0];
         lo  = q[W-1:0];
         dz  = 1'b0;
         lat = 8'(W + 2);
      end
      return {dz, lat, hi, lo};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int g = 0;
      while (md.busy !== 1'b0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_idle: busy stuck at %b after %0d cycles", md.busy, g);
      end
   endtask

   task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [EXP_W-1:0] e;
      wait_idle();
      e = ref_model(op, a, b);
      exp_q.push_back(e);
      issue_q.push_back(cyc);
      model_hi   = e[2*W-1:W];
      model_lo   = e[W-1:0];
      md.start   = 1'b1;
      md.op      = op;
      md.a_in    = a;
      md.b_in    = b;
      @(negedge clk);
      md.start   = 1'b0;
      md.a_in    = $urandom();
      md.b_in    = $urandom();
      md.op      = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done();
      int g = 0;
      while (exp_q.size() != 0 && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: %0d results outstanding", exp_q.size());
         exp_q.delete();
         issue_q.delete();
      end
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h0000_0001;
         4:       return W'($urandom_range(0, 20));
         default: return $urandom();
      endcase
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      logic [EXP_W-1:0] e;
      int               t;
      if (rst === 1'b0 && md.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: hi=0x%0h lo=0x%0h", md.hi, md.lo);
         end else begin
            e = exp_q.pop_front();
            t = issue_q.pop_front();
            check("hi", 64'(md.hi), 64'(e[2*W-1:W]));
            check("lo", 64'(md.lo), 64'(e[W-1:0]));
            check("div_zero", 64'(md.div_zero), 64'(e[EXP_W-1]));
            check("latency", 64'(cyc - t), 64'(e[EXP_W-2:2*W]));
            check("busy_at_done", 64'(md.busy), 64'd1);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      md.start = 1'b0;
      md.op    = MD_MULT;
      md.a_in  = '0;
      md.b_in  = '0;
      rst      = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(md.busy), 64'd0);
      check("rst_done", 64'(md.done), 64'd0);
      check("rst_div_zero", 64'(md.div_zero), 64'd0);
      check("rst_hi", 64'(md.hi), 64'd0);
      check("rst_lo", 64'(md.lo), 64'd0);
      check("rst_state", 64'(md.dbg_state), 64'(S_IDLE));
      rst = 1'b0;
      @(negedge clk);

      // Basic MULT with busy rise/fall tracking
      do_op(MD_MULT, 32'd7, 32'hFFFF_FFFD);
      check("busy_rise", 64'(md.busy), 64'd1);
      wait_done();
      @(negedge clk);
      check("busy_fall", 64'(md.busy), 64'd0);

      do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done();

      // Leaves hi=0x11, lo=0x22 for the divide-by-zero case
      do_op(MD_DIV, 32'h0000_0451, 32'h0000_0020);
      wait_done();
      do_op(MD_DIV, 32'd5, 32'd0);
      check("dz_busy_t1", 64'(md.busy), 64'd1);
      check("dz_flag_t1", 64'(md.div_zero), 64'd1);
      @(negedge clk);
      check("dz_busy_t2", 64'(md.busy), 64'd0);
      check("dz_done_t2", 64'(md.done), 64'd0);
      wait_done();

      do_op(MD_MULT, 32'h8000_0000, 32'h8000_0000);
      do_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
      do_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done();

      // Start during MUL and during DONE must be dropped
      do_op(MD_MULT, 32'h0000_1234, 32'hFFFF_5678);
      repeat (3) @(negedge clk);
      md.start = 1'b1;
      md.op    = MD_DIV;
      md.a_in  = 32'd9;
      md.b_in  = 32'd0;
      @(negedge clk);
      md.start = 1'b0;
      begin
         int g = 0;
         while (md.done !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
         end
      end
      md.start = 1'b1;
      md.op    = MD_MULT;
      md.a_in  = $urandom();
      md.b_in  = $urandom();
      @(negedge clk);
      md.start = 1'b0;
      check("start_in_done_dropped_a", 64'(md.busy), 64'd0);
      @(negedge clk);
      check("start_in_done_dropped_b", 64'(md.busy), 64'd0);
      wait_done();

      // Reset in the middle of a DIV
      do_op(MD_DIV, 32'h7654_3210, 32'h0000_0123);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      issue_q.delete();
      model_hi = '0;
      model_lo = '0;
      check("abort_busy", 64'(md.busy), 64'd0);
      check("abort_done", 64'(md.done), 64'd0);
      check("abort_hi", 64'(md.hi), 64'd0);
      check("abort_lo", 64'(md.lo), 64'd0);
      check("abort_state", 64'(md.dbg_state), 64'(S_IDLE));
      do_op(MD_MULT, 32'd3, 32'd4);
      wait_done();

      // Randomized back-to-back traffic
      for (int i = 0; i < 40; i++) begin
         logic         op;
         logic [W-1:0] a, b;
         op = 1'($urandom_range(0, 1));
         a  = pick_operand();
         b  = ($urandom_range(0, 5) == 0) ? '0 : pick_operand();
         do_op(op, a, b);
      end
      wait_done();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
